conv_mac_engine: RTL and testbench

- Pipelined, parametrised successor to the combinational 3x3 MAC.
- Accepts one KSIZE-tap window per beat: unsigned pixels and signed weights.
- Accumulates dot products over cfg_nch input channels, adds a bias, and emits one saturated signed result per frame over a valid/ready handshake.
- Sits between the line-buffer/window generator and the activation/pooling stage of the CNN datapath.

---
 rtl/conv_mac_pkg.sv | 51 +++++
 rtl/conv_mac_engine_dot.sv | 88 ++++++++
 rtl/conv_mac_engine.sv | 164 ++++++++++++++++
 tb/tb_conv_mac_engine.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_pkg.sv
// conv_mac_pkg: shared types and helpers for the convolution MAC engine.
//   state_t    - frame controller states (ACCUM, DRAIN, OUT)
//   sat_res_t  - saturating-add result: clamped value plus clamp flag
//   dot_width  - width of a KSIZE-tap dot product that can never overflow
//   sat_add    - signed add clamped to a w-bit two's-complement range
//                (w must be below SAT_W; operands are sign-extended to SAT_W)
package conv_mac_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    sat;
    } sat_res_t;

    // Product of a zero-extended pixel and a signed weight, plus growth for
    // the KSIZE-input sum.
    function automatic int dot_width(input int px_w, input int wt_w, input int ksize);
        return px_w + wt_w + 1 + $clog2(ksize);
    endfunction

    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                         input logic signed [SAT_W-1:0] b,
                                         input int                      w);
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sat_res_t              res;
        // One guard bit so the raw sum itself cannot wrap.
        sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi  = {{SAT_W{1'b0}}, 1'b1} << (w - 1);
        hi  = hi - {{SAT_W{1'b0}}, 1'b1};
        lo  = ~hi;
        res.sat = (sum > hi) || (sum < lo);
        if (sum > hi) begin
            res.value = hi[SAT_W-1:0];
        end else if (sum < lo) begin
            res.value = lo[SAT_W-1:0];
        end else begin
            res.value = sum[SAT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_mac_engine_dot.sv
// conv_mac_dot: KSIZE multipliers and an adder tree, two register stages.
//   P1 holds the KSIZE signed products, P2 holds their sum.
//   A valid/last sideband travels alongside the data.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   beat_valid, beat_last accepted beat and its end-of-frame tag
//   px, wt                KSIZE unsigned pixels / signed weights, tap0 in LSBs
//   dot_valid, dot_last   sideband aligned with dot
//   dot                   signed dot product (DOT_W bits, never overflows)
module conv_mac_dot
    import conv_mac_pkg::*;
#(
    parameter int PX_W  = 8,
    parameter int WT_W  = 8,
    parameter int KSIZE = 9,
    parameter int DOT_W = dot_width(PX_W, WT_W, KSIZE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    beat_valid,
    input  logic                    beat_last,
    input  logic [KSIZE*PX_W-1:0]   px,
    input  logic [KSIZE*WT_W-1:0]   wt,
    output logic                    dot_valid,
    output logic                    dot_last,
    output logic signed [DOT_W-1:0] dot
);

    localparam int PROD_W = PX_W + WT_W + 1;

    logic [KSIZE*PROD_W-1:0] prod_flat;
    logic                    p1_valid_reg;
    logic                    p1_last_reg;
    logic                    p2_valid_reg;
    logic                    p2_last_reg;
    logic signed [DOT_W-1:0] dot_reg;
    logic signed [DOT_W-1:0] dot_next;

    for (genvar gi = 0; gi < KSIZE; gi++) begin : g_tap
        logic signed [PROD_W-1:0] px_ext;
        logic signed [PROD_W-1:0] wt_ext;
        logic signed [PROD_W-1:0] prod_reg;

        // Leading 0 makes the pixel a non-negative signed operand.
        assign px_ext = PROD_W'($signed({1'b0, px[gi*PX_W +: PX_W]}));
        assign wt_ext = PROD_W'($signed(wt[gi*WT_W +: WT_W]));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod_reg <= '0;
            end else if (beat_valid) begin
                prod_reg <= px_ext * wt_ext;
            end
        end

        assign prod_flat[gi*PROD_W +: PROD_W] = prod_reg;
    end

    always_comb begin
        dot_next = '0;
        for (int k = 0; k < KSIZE; k++) begin
            dot_next = dot_next + DOT_W'($signed(prod_flat[k*PROD_W +: PROD_W]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_reg <= 1'b0;
            p1_last_reg  <= 1'b0;
            p2_valid_reg <= 1'b0;
            p2_last_reg  <= 1'b0;
            dot_reg      <= '0;
        end else begin
            p1_valid_reg <= beat_valid;
            p1_last_reg  <= beat_valid && beat_last;
            p2_valid_reg <= p1_valid_reg;
            p2_last_reg  <= p1_last_reg;
            if (p1_valid_reg) begin
                dot_reg <= dot_next;
            end
        end
    end

    assign dot_valid = p2_valid_reg;
    assign dot_last  = p2_last_reg;
    assign dot       = dot_reg;

endmodule

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: pipelined multi-channel 3x3 (KSIZE-tap) convolution MAC.
//   Accumulates cfg_nch window dot products, adds cfg_bias and emits one
//   saturated signed result per frame over a valid/ready handshake.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_nch, cfg_bias    channels per frame (0 means 1) and bias, latched at frame start
//   in_valid, in_ready   window beat handshake
//   in_px, in_wt         KSIZE pixels (unsigned) / weights (signed), tap0 in LSBs
//   out_valid, out_ready result handshake
//   out_data, out_sat    saturated result and "a clamp happened this frame"
// Build option: define CONV_MAC_RELU_EN to clamp negative results to zero
// (out_sat still reports the clamp before the ReLU).
module conv_mac_engine
    import conv_mac_pkg::*;
#(
    parameter int PX_W  = 8,
    parameter int WT_W  = 8,
    parameter int KSIZE = 9,
    parameter int ACC_W = 32,
    parameter int CH_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH_W-1:0]         cfg_nch,
    input  logic signed [ACC_W-1:0] cfg_bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [KSIZE*PX_W-1:0]   in_px,
    input  logic [KSIZE*WT_W-1:0]   in_wt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_sat
);

    localparam int DOT_W = dot_width(PX_W, WT_W, KSIZE);

    state_t                  state_reg;
    logic [CH_W-1:0]         cnt_reg;
    logic [CH_W-1:0]         nch_reg;
    logic [CH_W-1:0]         frame_nch;
    logic signed [ACC_W-1:0] bias_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] out_data_reg;
    logic signed [ACC_W-1:0] out_next;
    logic                    sat_reg;
    logic                    acc_last_reg;
    logic                    in_ready_reg;
    logic                    out_valid_reg;
    logic                    out_sat_reg;
    logic                    accept;
    logic                    beat_last;
    logic                    dot_valid;
    logic                    dot_last;
    logic signed [DOT_W-1:0] dot;
    sat_res_t                acc_res;
    sat_res_t                out_res;
    logic                    unused_hi;

    assign accept = in_valid && in_ready_reg;

    // On the first beat of a frame the live config applies; afterwards the latched one.
    assign frame_nch = (cnt_reg == '0) ? ((cfg_nch == '0) ? CH_W'(1) : cfg_nch) : nch_reg;
    assign beat_last = (cnt_reg == frame_nch - CH_W'(1));

    conv_mac_dot #(
        .PX_W  (PX_W),
        .WT_W  (WT_W),
        .KSIZE (KSIZE),
        .DOT_W (DOT_W)
    ) u_dot (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_valid (accept),
        .beat_last  (beat_last),
        .px         (in_px),
        .wt         (in_wt),
        .dot_valid  (dot_valid),
        .dot_last   (dot_last),
        .dot        (dot)
    );

    // Both adds happen at full width so a dot wider than ACC_W still clamps correctly.
    assign acc_res   = sat_add(SAT_W'(acc_reg), SAT_W'(dot), ACC_W);
    assign out_res   = sat_add(SAT_W'(acc_reg), SAT_W'(bias_reg), ACC_W);
    assign unused_hi = ^{acc_res.value[SAT_W-1:ACC_W], out_res.value[SAT_W-1:ACC_W]};

`ifdef CONV_MAC_RELU_EN
    assign out_next = out_res.value[ACC_W-1] ? '0 : out_res.value[ACC_W-1:0];
`else
    assign out_next = out_res.value[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_ACCUM;
            cnt_reg       <= '0;
            nch_reg       <= '0;
            bias_reg      <= '0;
            acc_reg       <= '0;
            sat_reg       <= 1'b0;
            acc_last_reg  <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            // ACC stage
            if (dot_valid) begin
                acc_reg <= acc_res.value[ACC_W-1:0];
                if (acc_res.sat) begin
                    sat_reg <= 1'b1;
                end
            end
            // Pulses in the cycle after the frame's last dot has been accumulated.
            acc_last_reg <= dot_valid && dot_last;

            case (state_reg)
                ST_ACCUM: begin
                    in_ready_reg <= !(accept && beat_last);
                    if (accept) begin
                        if (cnt_reg == '0) begin
                            nch_reg  <= frame_nch;
                            bias_reg <= cfg_bias;
                        end
                        if (beat_last) begin
                            cnt_reg   <= '0;
                            state_reg <= ST_DRAIN;
                        end else begin
                            cnt_reg <= cnt_reg + CH_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (acc_last_reg) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= out_next;
                        out_sat_reg   <= sat_reg || out_res.sat;
                        state_reg     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_sat_reg   <= 1'b0;
                        acc_reg       <= '0;
                        sat_reg       <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_ACCUM;
                    end
                end
                default: begin
                    state_reg <= ST_ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Testbench for conv_mac_engine: two instances (ACC_W=32 and ACC_W=20) share
// all stimulus; results are compared to an arithmetic frame model.
`timescale 1ns/1ps
module tb_conv_mac_engine;

    localparam int KS = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  cfg_nch = '0;
    logic [31:0] cfg_bias = '0;
    logic [19:0] cfg_bias20;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [71:0] in_px = '0;
    logic [71:0] in_wt = '0;
    logic        in_ready, out_valid, out_sat;
    logic        in_ready20, out_valid20, out_sat20;
    logic [31:0] out_data;
    logic [19:0] out_data20;

    int cyc = 0;
    int accept_cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int px_a [8][KS];
    int wt_a [8][KS];

    assign cfg_bias20 = cfg_bias[19:0];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_mac_engine dut (
        .clk(clk), .rst_n(rst_n), .cfg_nch(cfg_nch), .cfg_bias(cfg_bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_px(in_px), .in_wt(in_wt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    conv_mac_engine #(.ACC_W(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .cfg_nch(cfg_nch), .cfg_bias(cfg_bias20),
        .in_valid(in_valid), .in_ready(in_ready20), .in_px(in_px), .in_wt(in_wt),
        .out_valid(out_valid20), .out_ready(out_ready), .out_data(out_data20), .out_sat(out_sat20)
    );

    // ---------------- reference model ----------------
    function automatic void model(input int nch, input longint bias, input int acc_w,
                                  output longint data, output bit sat);
        longint hi, lo, acc, dot;
        int n;
        n   = (nch == 0) ? 1 : nch;
        hi  = (longint'(1) << (acc_w - 1)) - 1;
        lo  = -hi - 1;
        acc = 0;
        sat = 0;
        for (int ch = 0; ch < n; ch++) begin
            dot = 0;
            for (int t = 0; t < KS; t++) dot += longint'(px_a[ch][t] * wt_a[ch][t]);
            acc += dot;
            if (acc > hi) begin acc = hi; sat = 1; end
            if (acc < lo) begin acc = lo; sat = 1; end
        end
        acc += bias;
        if (acc > hi) begin acc = hi; sat = 1; end
        if (acc < lo) begin acc = lo; sat = 1; end
`ifdef CONV_MAC_RELU_EN
        if (acc < 0) acc = 0;
`endif
        data = acc;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input int n, input int px, input int wt);
        for (int b = 0; b < n; b++)
            for (int t = 0; t < KS; t++) begin px_a[b][t] = px; wt_a[b][t] = wt; end
    endtask

    task automatic fill_list(input int wl [KS]);
        for (int t = 0; t < KS; t++) begin px_a[0][t] = 1; wt_a[0][t] = wl[t]; end
    endtask

    task automatic fill_random(input int n);
        for (int b = 0; b < n; b++)
            for (int t = 0; t < KS; t++) begin
                px_a[b][t] = int'($urandom_range(0, 255));
                wt_a[b][t] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic send_beats(input int n, input bit gaps, input bit scramble, output bit tmo);
        tmo = 0;
        for (int b = 0; b < n; b++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 0;
                repeat ($urandom_range(1, 3)) step();
            end
            for (int t = 0; t < KS; t++) begin
                in_px[t*8 +: 8] = 8'(px_a[b][t]);
                in_wt[t*8 +: 8] = 8'(wt_a[b][t]);
            end
            in_valid = 1;
            for (int w = 0; w < 20 && !in_ready; w++) step();
            if (!in_ready) begin tmo = 1; break; end
            step();
            accept_cyc = cyc;
            if (scramble) begin cfg_nch = 8'($urandom); cfg_bias = $urandom; end
        end
        in_valid = 0;
    endtask

    task automatic wait_result(output bit got, output int lat);
        got = 0;
        for (int w = 0; w < 20; w++) begin
            if (out_valid) begin got = 1; break; end
            step();
        end
        lat = cyc - accept_cyc;
    endtask

    task automatic handshake();
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 rst_n = 0;
        step();
        n_vec++; if (in_ready !== 1'b0 || in_ready20 !== 1'b0) begin n_err++;
            $display("FAIL reset_in_ready: got %b/%b, required 0/0", in_ready, in_ready20); end
        n_vec++; if (out_valid !== 1'b0 || out_valid20 !== 1'b0) begin n_err++;
            $display("FAIL reset_out_valid: got %b/%b, required 0/0", out_valid, out_valid20); end
        n_vec++; if (out_data !== 32'd0 || out_data20 !== 20'd0 || out_sat !== 1'b0 || out_sat20 !== 1'b0) begin n_err++;
            $display("FAIL reset_out_data: got %h/%h sat %b/%b, required 0", out_data, out_data20, out_sat, out_sat20); end
        rst_n = 1;
        step();
        n_vec++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_basic();
        int wl [KS] = '{1, 0, -1, 1, 0, -1, 1, 0, -1};
        bit tmo, got, s, s20; int lat; longint e, e20;
        fill_list(wl); cfg_nch = 1; cfg_bias = 0;
        send_beats(1, 0, 0, tmo);
        wait_result(got, lat);
        model(1, 0, 32, e, s); model(1, 0, 20, e20, s20);
        n_vec++; if (tmo || !got || out_valid20 !== 1'b1) begin n_err++;
            $display("FAIL basic_result_seen: got=%0b tmo=%0b, required got=1 tmo=0", got, tmo); end
        n_vec++; if (lat !== 3) begin n_err++;
            $display("FAIL basic_latency: got %0d cycles, required 3", lat); end
        n_vec++; if (longint'($signed(out_data)) !== e || out_sat !== s) begin n_err++;
            $display("FAIL basic_data: got %0d sat %b, required %0d sat %b", $signed(out_data), out_sat, e, s); end
        n_vec++; if (longint'($signed(out_data20)) !== e20 || out_sat20 !== s20) begin n_err++;
            $display("FAIL basic_data20: got %0d sat %b, required %0d sat %b", $signed(out_data20), out_sat20, e20, s20); end
        handshake();
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL basic_after_hs: out_valid %b in_ready %b, required 0 1", out_valid, in_ready); end
    endtask

    task automatic test_bias();
        int wl [KS] = '{5, -2, 10, 12, -15, -20, 13, -5, 6};
        bit tmo, got, s; int lat; longint e;
        fill_list(wl); cfg_nch = 1; cfg_bias = -32'sd10;
        send_beats(1, 0, 0, tmo);
        wait_result(got, lat);
        model(1, -10, 32, e, s);
        n_vec++; if (!got || longint'($signed(out_data)) !== e || out_sat !== s) begin n_err++;
            $display("FAIL bias_data: got %0d sat %b valid %b, required %0d sat %b", $signed(out_data), out_sat, got, e, s); end
        n_vec++; if (longint'($signed(out_data20)) !== e) begin n_err++;
            $display("FAIL bias_data20: got %0d, required %0d", $signed(out_data20), e); end
        handshake();
    endtask

    task automatic test_back_to_back();
        bit tmo, got, s; int lat, hs_cyc; longint e;
        fill_const(3, 255, 2); cfg_nch = 3; cfg_bias = 0;
        send_beats(3, 0, 1, tmo);
        n_vec++; if (tmo || in_ready !== 1'b0) begin n_err++;
            $display("FAIL b2b_ready_after_last: got %b tmo %0b, required 0", in_ready, tmo); end
        wait_result(got, lat);
        model(3, 0, 32, e, s);
        n_vec++; if (!got || lat !== 3 || longint'($signed(out_data)) !== e) begin n_err++;
            $display("FAIL b2b_data: got %0d lat %0d, required %0d lat 3", $signed(out_data), lat, e); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++;
            $display("FAIL b2b_ready_in_out: got %b, required 0", in_ready); end
        handshake();
        hs_cyc = cyc;
        fill_random(1); cfg_nch = 1; cfg_bias = 32'd77;
        send_beats(1, 0, 0, tmo);
        n_vec++; if (tmo || accept_cyc - hs_cyc !== 1) begin n_err++;
            $display("FAIL b2b_next_accept: got %0d cycles after handshake, required 1", accept_cyc - hs_cyc); end
        wait_result(got, lat);
        model(1, 77, 32, e, s);
        n_vec++; if (!got || longint'($signed(out_data)) !== e) begin n_err++;
            $display("FAIL b2b_next_data: got %0d, required %0d", $signed(out_data), e); end
        handshake();
    endtask

    task automatic test_saturation();
        int wl [KS] = '{5, -2, 10, 12, -15, -20, 13, -5, 6};
        bit tmo, got, s, s20; int lat; longint e, e20;
        fill_const(2, 255, -128); cfg_nch = 2; cfg_bias = 0;
        send_beats(2, 0, 0, tmo);
        wait_result(got, lat);
        model(2, 0, 32, e, s); model(2, 0, 20, e20, s20);
        n_vec++; if (!got || longint'($signed(out_data20)) !== e20 || out_sat20 !== s20) begin n_err++;
            $display("FAIL sat_data20: got %0d sat %b, required %0d sat %b", $signed(out_data20), out_sat20, e20, s20); end
        n_vec++; if (longint'($signed(out_data)) !== e || out_sat !== s) begin n_err++;
            $display("FAIL sat_data32: got %0d sat %b, required %0d sat %b", $signed(out_data), out_sat, e, s); end
        handshake();
        fill_list(wl); cfg_nch = 1; cfg_bias = 0;
        send_beats(1, 0, 0, tmo);
        wait_result(got, lat);
        model(1, 0, 20, e20, s20);
        n_vec++; if (!got || longint'($signed(out_data20)) !== e20 || out_sat20 !== s20) begin n_err++;
            $display("FAIL sat_recover20: got %0d sat %b, required %0d sat %b", $signed(out_data20), out_sat20, e20, s20); end
        handshake();
    endtask

    task automatic test_hold();
        bit tmo, got, s; int lat; longint e; logic [31:0] d; logic ds;
        fill_random(2); cfg_nch = 2; cfg_bias = 32'd1000;
        send_beats(2, 0, 0, tmo);
        wait_result(got, lat);
        model(2, 1000, 32, e, s);
        n_vec++; if (!got || longint'($signed(out_data)) !== e || out_sat !== s) begin n_err++;
            $display("FAIL hold_data: got %0d sat %b, required %0d sat %b", $signed(out_data), out_sat, e, s); end
        d = 32'(e); ds = s;
        in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++; if (out_valid !== 1'b1 || out_data !== d || out_sat !== ds || in_ready !== 1'b0) begin n_err++;
                $display("FAIL hold_stable[%0d]: valid %b data %h in_ready %b, required 1 %h 0", i, out_valid, out_data, in_ready, d); end
        end
        in_valid = 0;
        handshake();
    endtask

    task automatic test_gaps();
        bit tmo, got, s; int lat; longint e;
        fill_random(4); cfg_nch = 4; cfg_bias = -32'sd5000;
        for (int pass = 0; pass < 2; pass++) begin
            cfg_nch = 4; cfg_bias = -32'sd5000;
            send_beats(4, pass == 1, 1, tmo);
            wait_result(got, lat);
            model(4, -5000, 32, e, s);
            n_vec++; if (tmo || !got || longint'($signed(out_data)) !== e || out_sat !== s) begin n_err++;
                $display("FAIL gaps_pass%0d: got %0d sat %b, required %0d sat %b", pass, $signed(out_data), out_sat, e, s); end
            handshake();
        end
    endtask

    task automatic test_reset_mid();
        bit tmo, got, s; int lat; longint e;
        fill_const(3, 255, 3); cfg_nch = 3; cfg_bias = 0;
        send_beats(2, 0, 0, tmo);
        rst_n = 0;
        #1;
        n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL rstmid_async: in_ready %b out_valid %b, required 0 0", in_ready, out_valid); end
        step(); step();
        rst_n = 1;
        step();
        fill_random(1); cfg_nch = 1; cfg_bias = 32'd12;
        send_beats(1, 0, 0, tmo);
        wait_result(got, lat);
        model(1, 12, 32, e, s);
        n_vec++; if (tmo || !got || longint'($signed(out_data)) !== e) begin n_err++;
            $display("FAIL rstmid_new_frame: got %0d, required %0d", $signed(out_data), e); end
        handshake();
    endtask

    task automatic test_random();
        bit tmo, got, s, s20; int lat, nch; longint e, e20, bias;
        for (int f = 0; f < 10; f++) begin
            nch  = int'($urandom_range(0, 4));
            bias = longint'($urandom_range(0, 400000)) - 200000;
            fill_random(nch == 0 ? 1 : nch);
            cfg_nch = 8'(nch); cfg_bias = 32'(bias);
            send_beats(nch == 0 ? 1 : nch, 1, 1, tmo);
            wait_result(got, lat);
            model(nch, bias, 32, e, s); model(nch, bias, 20, e20, s20);
            n_vec++; if (tmo || !got || lat !== 3) begin n_err++;
                $display("FAIL rand%0d_timing: got=%0b lat %0d, required 3", f, got, lat); end
            n_vec++; if (longint'($signed(out_data)) !== e || out_sat !== s) begin n_err++;
                $display("FAIL rand%0d_data: got %0d sat %b, required %0d sat %b", f, $signed(out_data), out_sat, e, s); end
            n_vec++; if (longint'($signed(out_data20)) !== e20 || out_sat20 !== s20) begin n_err++;
                $display("FAIL rand%0d_data20: got %0d sat %b, required %0d sat %b", f, $signed(out_data20), out_sat20, e20, s20); end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bias();
        test_back_to_back();
        test_saturation();
        test_hold();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
